nurn_update_ctrl: RTL and testbench
===================================

Name: nurn_update_ctrl

Overview:
Per-timestep neuron update sequencer that sits directly upstream of the status memory and drives its read port A, write port B and weight read port E. On start it walks every neuron. For each neuron it reads Bias, MembPot, Th and PostSpikeHist, then integrates the weights of all spiking axons. It then computes the new membrane potential with a threshold test, writes MembPot and PostSpikeHist back, and emits a spike event.

Parameters:
NUM_NURNS, 256, neurons per core
NUM_AXONS, 256, axons per core
DSIZE, 16, status/weight word width, signed two's complement
NURN_CNT_BIT_WIDTH, 8, log2(NUM_NURNS)
AXON_CNT_BIT_WIDTH, 8, log2(NUM_AXONS)
STDP_WIN_BIT_WIDTH, 8, PostSpikeHist width
RESET_POT, 0, MembPot value loaded after a spike

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  timestep start pulse
axon_spikes_i  in  NUM_AXONS  input spike vector, sampled on accepted start_i
busy_o  out  1  high from accepted start to done_o
done_o  out  1  one-cycle pulse after last neuron written
spike_o  out  1  one-cycle spike pulse
spike_nurn_o  out  NURN_CNT_BIT_WIDTH  neuron index qualified by spike_o
Addr_StatRd_A_o  out  NURN_CNT_BIT_WIDTH+2  {nurn, sel}; sel 00 Bias, 01 MembPot, 10 Th, 11 PostSpikeHist
rdEn_StatRd_A_o  out  1  port A read enable
data_StatRd_A_i  in  DSIZE  port A data, valid the cycle after rdEn
Addr_StatWr_B_o  out  NURN_CNT_BIT_WIDTH+2  {nurn, sel}
wrEn_StatWr_B_o  out  1  port B write enable
data_StatWr_B_o  out  DSIZE  port B write data
Addr_StatRd_E_o  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  {nurn, axon} weight address
rdEn_StatRd_E_o  out  1  port E read enable
data_StatRd_E_i  in  DSIZE  weight, valid the cycle after rdEn

Behaviour:
- Reset (rst_i high at clk edge): state IDLE. All outputs 0: busy, done, spike, every enable, address and data.
- Reset mid-operation aborts the walk: no further reads or writes, no done_o.
- IDLE: start_i latches axon_spikes_i, sets nurn=0 and goes to RD. busy_o rises the next cycle. start_i while busy is ignored.
- RD, 4 cycles: rdEn_A=1 with sel 00,01,10,11 in consecutive cycles. Bias, Pot, Th and Hist are captured one cycle after each issue, so Hist is captured in the first INTEG cycle.
- INTEG, NUM_AXONS scan cycles plus 1 drain cycle:
  - Axon counter a runs 0..NUM_AXONS-1, one per cycle.
  - rdEn_E=1 with addr {nurn,a} only when the latched spike bit a is 1.
  - Each returned weight is added to the accumulator the following cycle.
  - The accumulator is signed, DSIZE+AXON_CNT_BIT_WIDTH+2 bits wide, and is cleared on entry.
- CALC, 1 cycle:
  - sum = Pot + Bias + acc in full width, saturated to the DSIZE signed range (0x7FFF / 0x8000 at 16 bits).
  - fire = (sat_sum >= Th), signed compare.
- WR_POT, 1 cycle: wrEn_B=1, sel 01, data = fire ? RESET_POT : sat_sum. spike_o=1 with spike_nurn_o=nurn in this cycle iff fire.
- WR_HIST, 1 cycle:
  - wrEn_B=1, sel 11.
  - data = fire ? 0 : Hist+1, saturating at 2^STDP_WIN_BIT_WIDTH-1, zero-extended to DSIZE.
  - If nurn == NUM_NURNS-1, go to DONE; else nurn+1 and go to RD.
- DONE, 1 cycle: done_o=1, busy_o falls, return to IDLE.
- Timing: per-neuron latency is NUM_AXONS+8 cycles. Total from accepted start to done_o is NUM_NURNS*(NUM_AXONS+8)+1 cycles.
- Port A and port E are never enabled in the same cycle as wrEn_B. Enables are 0 in every unlisted state.
- An all-zero spike vector issues no port E reads, and acc=0.

Test Plan:
- NUM_NURNS=4, NUM_AXONS=8. Neuron 0: Bias=2, Pot=10, Th=20, weights a1=5, a3=4, spikes=0b00001010 -> sum 21, spike_o with nurn 0, MembPot=0, Hist=0.
- Neuron 1: Bias=1, Pot=3, Th=100, Hist=5, same spikes, weights 2/2 -> MembPot=8, Hist=6, no spike; exactly 2 port E reads for this neuron.
- Saturation, neuron 2:
  - Pot=0x7FF0, Bias=0, weight 0x0100, Th=0x7FFF -> sum 0x7FFF, spike.
  - Pot=0x8010, weight 0xFF00, Th=0 -> MembPot=0x8000, no spike.
  - Hist=0xFF with no spike -> stays 0xFF.
- Timing check: start_i pulse -> busy_o next cycle; done_o exactly 4*16+1=65 cycles after start. start_i pulses during busy produce no restart.
- Reset mid-operation: assert rst_i during INTEG of neuron 1 -> next cycle all enables 0, no write to neuron 1, no done_o. A subsequent start re-walks from neuron 0.

Source files
------------

// File: rtl/nurn_update_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nurn_update_ctrl : per-timestep neuron update sequencer (status/weight memory)
// Rev 1.0
// ----------------------------------------------------------------------------
module nurn_update_ctrl #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int STDP_WIN_BIT_WIDTH = 8,
  parameter int RESET_POT          = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [NUM_AXONS-1:0]                         axon_spikes_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         spike_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                spike_nurn_o,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatRd_A_o,
  output logic                                         rdEn_StatRd_A_o,
  input  logic [DSIZE-1:0]                             data_StatRd_A_i,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatWr_B_o,
  output logic                                         wrEn_StatWr_B_o,
  output logic [DSIZE-1:0]                             data_StatWr_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o,
  output logic                                         rdEn_StatRd_E_o,
  input  logic [DSIZE-1:0]                             data_StatRd_E_i
);

  localparam int ACC_W = DSIZE + AXON_CNT_BIT_WIDTH + 2;

  localparam logic [1:0] SEL_BIAS = 2'd0;
  localparam logic [1:0] SEL_POT  = 2'd1;
  localparam logic [1:0] SEL_TH   = 2'd2;
  localparam logic [1:0] SEL_HIST = 2'd3;

  localparam logic [NURN_CNT_BIT_WIDTH-1:0] NURN_LAST = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] AXON_LAST = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

  // Signed DSIZE range limits, sign-extended to accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DSIZE+1){1'b0}}, {(DSIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DSIZE+1){1'b1}}, {(DSIZE-1){1'b0}}};

  localparam logic [DSIZE-1:0] RESET_POT_W = DSIZE'(RESET_POT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_INTEG   = 3'd2,
    S_CALC    = 3'd3,
    S_WR_POT  = 3'd4,
    S_WR_HIST = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_AXONS-1:0]              spikes_q, spikes_d;
  logic [NURN_CNT_BIT_WIDTH-1:0]     nurn_q, nurn_d;
  logic [1:0]                        sel_q, sel_d;
  logic [AXON_CNT_BIT_WIDTH-1:0]     axon_q, axon_d;
  logic                              drain_q, drain_d;

  logic                              rd_vld_q;
  logic [1:0]                        rd_sel_q;
  logic                              e_vld_q;

  logic [DSIZE-1:0]                  bias_q, pot_q, th_q;
  logic [STDP_WIN_BIT_WIDTH-1:0]     hist_q;
  logic signed [ACC_W-1:0]           acc_q, acc_d;
  logic [DSIZE-1:0]                  sat_q, sat_d;
  logic                              fire_q, fire_d;

  logic signed [ACC_W-1:0]           sum;
  logic [STDP_WIN_BIT_WIDTH-1:0]     hist_inc;

  // Full-width sum of the three terms, then clamp into the word range
  always_comb begin
    sum = acc_q
        + {{(ACC_W-DSIZE){pot_q[DSIZE-1]}},  pot_q}
        + {{(ACC_W-DSIZE){bias_q[DSIZE-1]}}, bias_q};
    if (sum > SAT_MAX) begin
      sat_d = SAT_MAX[DSIZE-1:0];
    end else if (sum < SAT_MIN) begin
      sat_d = SAT_MIN[DSIZE-1:0];
    end else begin
      sat_d = sum[DSIZE-1:0];
    end
    fire_d   = ($signed(sat_d) >= $signed(th_q));
    hist_inc = (&hist_q) ? hist_q : hist_q + STDP_WIN_BIT_WIDTH'(1);
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == S_RD) begin
      acc_d = '0;
    end else if (e_vld_q) begin
      acc_d = acc_q + {{(ACC_W-DSIZE){data_StatRd_E_i[DSIZE-1]}}, data_StatRd_E_i};
    end
  end

  always_comb begin
    state_d         = state_q;
    spikes_d        = spikes_q;
    nurn_d          = nurn_q;
    sel_d           = sel_q;
    axon_d          = axon_q;
    drain_d         = drain_q;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    spike_o         = 1'b0;
    spike_nurn_o    = '0;
    Addr_StatRd_A_o = '0;
    rdEn_StatRd_A_o = 1'b0;
    Addr_StatWr_B_o = '0;
    wrEn_StatWr_B_o = 1'b0;
    data_StatWr_B_o = '0;
    Addr_StatRd_E_o = '0;
    rdEn_StatRd_E_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          spikes_d = axon_spikes_i;
          nurn_d   = '0;
          sel_d    = '0;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        busy_o          = 1'b1;
        rdEn_StatRd_A_o = 1'b1;
        Addr_StatRd_A_o = {nurn_q, sel_q};
        sel_d           = sel_q + 2'd1;
        if (sel_q == SEL_HIST) begin
          axon_d  = '0;
          drain_d = 1'b0;
          state_d = S_INTEG;
        end
      end
      S_INTEG: begin
        busy_o = 1'b1;
        if (!drain_q) begin
          if (spikes_q[axon_q]) begin
            rdEn_StatRd_E_o = 1'b1;
            Addr_StatRd_E_o = {nurn_q, axon_q};
          end
          if (axon_q == AXON_LAST) begin
            drain_d = 1'b1;
          end else begin
            axon_d = axon_q + AXON_CNT_BIT_WIDTH'(1);
          end
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        busy_o  = 1'b1;
        state_d = S_WR_POT;
      end
      S_WR_POT: begin
        busy_o          = 1'b1;
        wrEn_StatWr_B_o = 1'b1;
        Addr_StatWr_B_o = {nurn_q, SEL_POT};
        data_StatWr_B_o = fire_q ? RESET_POT_W : sat_q;
        spike_o         = fire_q;
        spike_nurn_o    = fire_q ? nurn_q : '0;
        state_d         = S_WR_HIST;
      end
      S_WR_HIST: begin
        busy_o          = 1'b1;
        wrEn_StatWr_B_o = 1'b1;
        Addr_StatWr_B_o = {nurn_q, SEL_HIST};
        data_StatWr_B_o = fire_q ? '0 : DSIZE'(hist_inc);
        if (nurn_q == NURN_LAST) begin
          state_d = S_DONE;
        end else begin
          nurn_d  = nurn_q + NURN_CNT_BIT_WIDTH'(1);
          sel_d   = '0;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      spikes_q <= '0;
      nurn_q   <= '0;
      sel_q    <= '0;
      axon_q   <= '0;
      drain_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_sel_q <= '0;
      e_vld_q  <= 1'b0;
      acc_q    <= '0;
      sat_q    <= '0;
      fire_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      nurn_q   <= nurn_d;
      sel_q    <= sel_d;
      axon_q   <= axon_d;
      drain_q  <= drain_d;
      rd_vld_q <= rdEn_StatRd_A_o;
      rd_sel_q <= Addr_StatRd_A_o[1:0];
      e_vld_q  <= rdEn_StatRd_E_o;
      acc_q    <= acc_d;
      if (state_q == S_CALC) begin
        sat_q  <= sat_d;
        fire_q <= fire_d;
      end
    end
  end

  // Read data lands one cycle after issue; the HIST word lands in the first INTEG cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bias_q <= '0;
      pot_q  <= '0;
      th_q   <= '0;
      hist_q <= '0;
    end else if (rd_vld_q) begin
      case (rd_sel_q)
        SEL_BIAS: bias_q <= data_StatRd_A_i;
        SEL_POT:  pot_q  <= data_StatRd_A_i;
        SEL_TH:   th_q   <= data_StatRd_A_i;
        default:  hist_q <= data_StatRd_A_i[STDP_WIN_BIT_WIDTH-1:0];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nurn_update_ctrl.sv
`default_nettype none
// tb_nurn_update_ctrl : status/weight memory model plus a per-neuron arithmetic reference.
module tb_nurn_update_ctrl;

  localparam int NN = 4;
  localparam int NA = 8;
  localparam int NB = 2;
  localparam int AB = 3;
  localparam int DS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NA-1:0] spikes = '0;
  logic busy_o, done_o, spike_o;
  logic [NB-1:0] spike_nurn_o;
  logic [NB+1:0] Addr_A, Addr_B;
  logic rdEn_A, wrEn_B, rdEn_E;
  logic [DS-1:0] data_A = '0;
  logic [DS-1:0] data_E = '0;
  logic [DS-1:0] data_B;
  logic [NB+AB-1:0] Addr_E;

  always #5 clk = ~clk;

  nurn_update_ctrl #(
    .NUM_NURNS(NN), .NUM_AXONS(NA), .DSIZE(DS), .NURN_CNT_BIT_WIDTH(NB),
    .AXON_CNT_BIT_WIDTH(AB), .STDP_WIN_BIT_WIDTH(8), .RESET_POT(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .axon_spikes_i(spikes),
    .busy_o(busy_o), .done_o(done_o), .spike_o(spike_o), .spike_nurn_o(spike_nurn_o),
    .Addr_StatRd_A_o(Addr_A), .rdEn_StatRd_A_o(rdEn_A), .data_StatRd_A_i(data_A),
    .Addr_StatWr_B_o(Addr_B), .wrEn_StatWr_B_o(wrEn_B), .data_StatWr_B_o(data_B),
    .Addr_StatRd_E_o(Addr_E), .rdEn_StatRd_E_o(rdEn_E), .data_StatRd_E_i(data_E)
  );

  // memory: [neuron][0 bias, 1 pot, 2 th, 3 hist]
  logic [DS-1:0] mem      [NN][4];
  logic [DS-1:0] init_mem [NN][4];
  logic [DS-1:0] wgt      [NN][NA];
  logic          load_req = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) begin
      for (int n = 0; n < NN; n++)
        for (int s = 0; s < 4; s++) mem[n][s] <= init_mem[n][s];
    end else if (wrEn_B) begin
      mem[Addr_B[NB+1:2]][Addr_B[1:0]] <= data_B;
    end
    if (rdEn_A) data_A <= mem[Addr_A[NB+1:2]][Addr_A[1:0]];
    if (rdEn_E) data_E <= wgt[Addr_E[NB+AB-1:AB]][Addr_E[AB-1:0]];
  end

  // cumulative activity log
  int ecnt  [NN] = '{default: 0};
  int wrcnt [NN] = '{default: 0};
  int conflicts = 0;
  int done_cnt  = 0;
  int spk_q[$];

  always @(negedge clk) begin
    if (rdEn_E) ecnt[Addr_E[NB+AB-1:AB]] = ecnt[Addr_E[NB+AB-1:AB]] + 1;
    if (wrEn_B) wrcnt[Addr_B[NB+1:2]] = wrcnt[Addr_B[NB+1:2]] + 1;
    if (wrEn_B && (rdEn_A || rdEn_E)) conflicts = conflicts + 1;
    if (spike_o) spk_q.push_back(int'(spike_nurn_o));
    if (done_o) done_cnt = done_cnt + 1;
  end

  logic [DS-1:0] exp_mem [NN][4];
  int exp_spk[$];
  int exp_e [NN];
  int total = 0;
  int bad = 0;

  // Reference: each neuron's new state from the stored words, weights and spike vector
  task automatic compute_expected();
    int acc, s, th, h;
    bit fire;
    exp_spk.delete();
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      exp_e[n] = 0;
      for (int a = 0; a < NA; a++) begin
        if (spikes[a]) begin
          acc = acc + int'($signed(wgt[n][a]));
          exp_e[n]++;
        end
      end
      s  = int'($signed(mem[n][1])) + int'($signed(mem[n][0])) + acc;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      th   = int'($signed(mem[n][2]));
      fire = (s >= th);
      h    = int'(mem[n][3]) & 255;
      exp_mem[n][0] = mem[n][0];
      exp_mem[n][2] = mem[n][2];
      exp_mem[n][1] = fire ? 16'h0000 : 16'(s);
      exp_mem[n][3] = fire ? 16'h0000 : ((h == 255) ? 16'd255 : 16'(h + 1));
      if (fire) exp_spk.push_back(n);
    end
  endtask

  task automatic load_mem();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    #1;
  endtask

  task automatic run_walk(output bit ok, output int lat);
    int t0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin ok = 1'b1; lat = cyc - t0; break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic set_default_weights();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NA; a++) wgt[n][a] = 16'd1000;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0 || spike_o !== 1'b0) begin
      bad++; $display("FAIL reset_flags: busy=%b done=%b spike=%b want 000", busy_o, done_o, spike_o); end
    total++; if ({rdEn_A, wrEn_B, rdEn_E} !== 3'b000) begin
      bad++; $display("FAIL reset_enables: got %b want 000", {rdEn_A, wrEn_B, rdEn_E}); end
    total++; if ({Addr_A, Addr_B, Addr_E, spike_nurn_o} !== '0) begin
      bad++; $display("FAIL reset_addr: A=%h B=%h E=%h nurn=%h want 0", Addr_A, Addr_B, Addr_E, spike_nurn_o); end
    total++; if (data_B !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", data_B); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bit ok; int lat, sb; int eb [NN];
    set_default_weights();
    init_mem[0] = '{16'd2, 16'd10, 16'd20, 16'd0};
    init_mem[1] = '{16'd1, 16'd3, 16'd100, 16'd5};
    init_mem[2] = '{16'd0, 16'h7FF0, 16'h7FFF, 16'd0};
    init_mem[3] = '{16'd0, 16'd0, 16'h7FFF, 16'h00FF};
    wgt[0][1] = 16'd5;     wgt[0][3] = 16'd4;
    wgt[1][1] = 16'd2;     wgt[1][3] = 16'd2;
    wgt[2][1] = 16'h0100;  wgt[2][3] = 16'd0;
    wgt[3][1] = 16'd0;     wgt[3][3] = 16'd0;
    spikes = 8'b0000_1010;
    load_mem();
    compute_expected();
    sb = spk_q.size();
    for (int n = 0; n < NN; n++) eb[n] = ecnt[n];
    run_walk(ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL dir_done: done_o not seen within bound"); end
    total++; if (mem[0][1] !== 16'h0000 || mem[0][3] !== 16'h0000) begin
      bad++; $display("FAIL dir_n0: pot=%h hist=%h want 0000 0000", mem[0][1], mem[0][3]); end
    total++; if (mem[1][1] !== 16'd8 || mem[1][3] !== 16'd6) begin
      bad++; $display("FAIL dir_n1: pot=%0d hist=%0d want 8 6", mem[1][1], mem[1][3]); end
    total++; if (ecnt[1] - eb[1] != 2) begin
      bad++; $display("FAIL dir_n1_ereads: got %0d want 2", ecnt[1] - eb[1]); end
    total++; if (mem[2][1] !== 16'h0000) begin
      bad++; $display("FAIL dir_n2_possat: pot=%h want 0000", mem[2][1]); end
    total++; if (mem[3][3] !== 16'h00FF) begin
      bad++; $display("FAIL dir_hist_sat: hist=%h want 00ff", mem[3][3]); end
    total++; if (spk_q.size() - sb != 2 || spk_q[sb] != 0 || spk_q[sb+1] != 2) begin
      bad++; $display("FAIL dir_spikes: count=%0d want 2 (neurons 0,2)", spk_q.size() - sb); end
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < 4; s++) begin
        total++; if (mem[n][s] !== exp_mem[n][s]) begin
          bad++; $display("FAIL dir_mem[%0d][%0d]: got %h want %h", n, s, mem[n][s], exp_mem[n][s]); end
      end
  endtask

  task automatic test_saturation();
    bit ok; int lat, sb;
    set_default_weights();
    init_mem[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd3};
    init_mem[1] = '{16'h8000, 16'h8000, 16'h8000, 16'd3};
    init_mem[2] = '{16'h0000, 16'h8010, 16'h0000, 16'd7};
    init_mem[3] = '{16'hFFFF, 16'h8000, 16'h8001, 16'd9};
    wgt[0][1] = 16'h7FFF; wgt[0][3] = 16'h7FFF;
    wgt[1][1] = 16'h8000; wgt[1][3] = 16'h8000;
    wgt[2][1] = 16'hFF00; wgt[2][3] = 16'h0000;
    wgt[3][1] = 16'h0000; wgt[3][3] = 16'h0000;
    spikes = 8'b0000_1010;
    load_mem();
    compute_expected();
    sb = spk_q.size();
    run_walk(ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL sat_done: done_o not seen within bound"); end
    total++; if (mem[2][1] !== 16'h8000 || mem[2][3] !== 16'd8) begin
      bad++; $display("FAIL sat_neg: pot=%h hist=%h want 8000 0008", mem[2][1], mem[2][3]); end
    total++; if (mem[3][1] !== 16'h8000) begin
      bad++; $display("FAIL sat_neg_nofire: pot=%h want 8000", mem[3][1]); end
    total++; if (spk_q.size() - sb != 2 || spk_q[sb] != 0 || spk_q[sb+1] != 1) begin
      bad++; $display("FAIL sat_spikes: count=%0d want 2 (neurons 0,1)", spk_q.size() - sb); end
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < 4; s++) begin
        total++; if (mem[n][s] !== exp_mem[n][s]) begin
          bad++; $display("FAIL sat_mem[%0d][%0d]: got %h want %h", n, s, mem[n][s], exp_mem[n][s]); end
      end
  endtask

  task automatic test_zero_spikes();
    bit ok; int lat;
    int eb [NN];
    for (int n = 0; n < NN; n++) begin
      init_mem[n] = '{16'(n + 1), 16'(10 * n), 16'd500, 16'(n)};
      for (int a = 0; a < NA; a++) wgt[n][a] = 16'(a + 1);
    end
    spikes = '0;
    load_mem();
    compute_expected();
    for (int n = 0; n < NN; n++) eb[n] = ecnt[n];
    run_walk(ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL zero_done: done_o not seen within bound"); end
    for (int n = 0; n < NN; n++) begin
      total++; if (ecnt[n] != eb[n]) begin
        bad++; $display("FAIL zero_ereads[%0d]: got %0d want 0", n, ecnt[n] - eb[n]); end
      total++; if (mem[n][1] !== exp_mem[n][1] || mem[n][3] !== exp_mem[n][3]) begin
        bad++; $display("FAIL zero_mem[%0d]: pot=%h hist=%h want %h %h", n, mem[n][1], mem[n][3], exp_mem[n][1], exp_mem[n][3]); end
    end
  endtask

  task automatic test_timing();
    int t0, lat, db, busy_drops;
    bit seen;
    spikes = 8'($urandom);
    db = done_cnt;
    busy_drops = 0;
    seen = 1'b0;
    lat = 0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL tim_busy_rise: got %b want 1", busy_o); end
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin seen = 1'b1; lat = cyc - t0; break; end
      if (busy_o !== 1'b1) busy_drops++;
      start = (cyc - t0 == 10 || cyc - t0 == 30) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (!seen || lat != 65) begin
      bad++; $display("FAIL tim_latency: seen=%b got %0d want 65", seen, lat); end
    total++; if (busy_drops != 0) begin
      bad++; $display("FAIL tim_busy_hold: busy low %0d cycles want 0", busy_drops); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL tim_busy_fall: got %b want 0", busy_o); end
    busy_drops = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_o !== 1'b0) busy_drops++;
    end
    #1;
    total++; if (busy_drops != 0 || done_cnt - db != 1) begin
      bad++; $display("FAIL tim_no_restart: busy_cycles=%0d dones=%0d want 0 1", busy_drops, done_cnt - db); end
  endtask

  task automatic test_reset_mid();
    int t0, wb, db, sb;
    bit hit, ok;
    int lat;
    logic [DS-1:0] snap [4];
    set_default_weights();
    for (int n = 0; n < NN; n++)
      init_mem[n] = '{16'(n), 16'(20 + n), 16'd30, 16'(n + 2)};
    spikes = 8'b0000_1010;
    load_mem();
    for (int s = 0; s < 4; s++) snap[s] = mem[1][s];
    wb = wrcnt[1]; db = done_cnt;
    hit = 1'b0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cyc - t0 == 22) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!hit || rdEn_E !== 1'b1 || Addr_E !== 5'b01_001) begin
      bad++; $display("FAIL mid_integ_n1: rdEn_E=%b addr=%b want 1 01001", rdEn_E, Addr_E); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({rdEn_A, wrEn_B, rdEn_E, busy_o} !== 4'b0000) begin
      bad++; $display("FAIL mid_abort: rdA/wrB/rdE/busy=%b want 0000", {rdEn_A, wrEn_B, rdEn_E, busy_o}); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    total++; if (wrcnt[1] != wb || done_cnt != db) begin
      bad++; $display("FAIL mid_no_write: n1 writes=%0d dones=%0d want 0 0", wrcnt[1] - wb, done_cnt - db); end
    for (int s = 0; s < 4; s++) begin
      total++; if (mem[1][s] !== snap[s]) begin
        bad++; $display("FAIL mid_n1_mem[%0d]: got %h want %h", s, mem[1][s], snap[s]); end
    end
    compute_expected();
    sb = spk_q.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (rdEn_A !== 1'b1 || Addr_A !== 4'b0000) begin
      bad++; $display("FAIL mid_restart_n0: rdEn_A=%b addr=%b want 1 0000", rdEn_A, Addr_A); end
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
    total++; if (!ok) begin bad++; $display("FAIL mid_restart_done: done_o not seen"); end
    total++; if (spk_q.size() - sb != exp_spk.size()) begin
      bad++; $display("FAIL mid_spikes: got %0d want %0d", spk_q.size() - sb, exp_spk.size()); end
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < 4; s++) begin
        total++; if (mem[n][s] !== exp_mem[n][s]) begin
          bad++; $display("FAIL mid_mem[%0d][%0d]: got %h want %h", n, s, mem[n][s], exp_mem[n][s]); end
      end
  endtask

  task automatic test_random();
    bit ok; int lat, sb, cb, v;
    int eb [NN];
    for (int it = 0; it < 6; it++) begin
      for (int n = 0; n < NN; n++) begin
        for (int s = 0; s < 3; s++)
          init_mem[n][s] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200));
        init_mem[n][3] = ($urandom_range(0, 3) == 0) ? 16'h00FF : 16'($urandom);
        for (int a = 0; a < NA; a++) begin
          v = int'($urandom_range(0, 64)) - 32;
          wgt[n][a] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(v);
        end
      end
      spikes = 8'($urandom);
      load_mem();
      compute_expected();
      sb = spk_q.size(); cb = conflicts;
      for (int n = 0; n < NN; n++) eb[n] = ecnt[n];
      run_walk(ok, lat);
      total++; if (!ok || lat != 65) begin
        bad++; $display("FAIL rnd%0d_latency: seen=%b got %0d want 65", it, ok, lat); end
      total++; if (conflicts != cb) begin
        bad++; $display("FAIL rnd%0d_port_overlap: got %0d want 0", it, conflicts - cb); end
      total++; if (spk_q.size() - sb != exp_spk.size()) begin
        bad++; $display("FAIL rnd%0d_spike_count: got %0d want %0d", it, spk_q.size() - sb, exp_spk.size()); end
      else begin
        for (int k = 0; k < exp_spk.size(); k++) begin
          total++; if (spk_q[sb+k] != exp_spk[k]) begin
            bad++; $display("FAIL rnd%0d_spike[%0d]: got %0d want %0d", it, k, spk_q[sb+k], exp_spk[k]); end
        end
      end
      for (int n = 0; n < NN; n++) begin
        total++; if (ecnt[n] - eb[n] != exp_e[n]) begin
          bad++; $display("FAIL rnd%0d_ereads[%0d]: got %0d want %0d", it, n, ecnt[n] - eb[n], exp_e[n]); end
        for (int s = 0; s < 4; s++) begin
          total++; if (mem[n][s] !== exp_mem[n][s]) begin
            bad++; $display("FAIL rnd%0d_mem[%0d][%0d]: got %h want %h", it, n, s, mem[n][s], exp_mem[n][s]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_zero_spikes();
    test_timing();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
